game_round_sequencer: RTL and testbench

//  Round-level controller for the factorization game. Sequences question/answer rounds, owns the

---
 rtl/game_round_sequencer.sv | 152 +++++++++++++++
 tb/tb_game_round_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - Round sequencer: question flow, HP/damage, per-question timer, win/lose detection.
module game_round_sequencer #(
    parameter int unsigned HP_MAX      = 9,
    parameter int unsigned TIME_LIMIT  = 10,
    parameter int unsigned WIN_COUNT   = 5,
    parameter int unsigned DMG_WRONG   = 1,
    parameter int unsigned DMG_TIMEOUT = 2,
    parameter int unsigned BLINK_TICKS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       tick_i,
    input  logic       judg_valid_i,
    input  logic [1:0] judg_i,
    output logic [2:0] state_o,
    output logic [3:0] hp_o,
    output logic [3:0] time_left_o,
    output logic [2:0] score_o,
    output logic       next_q_o,
    output logic       damage_o,
    output logic       blink_o,
    output logic       game_over_o,
    output logic       game_clear_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ASK   = 3'd1,
        S_HIT   = 3'd2,
        S_NEXT  = 3'd3,
        S_OVER  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    localparam logic [3:0] HP_MAX_C      = 4'(HP_MAX);
    localparam logic [3:0] TIME_LIMIT_C  = 4'(TIME_LIMIT);
    localparam logic [2:0] WIN_COUNT_C   = 3'(WIN_COUNT);
    localparam logic [3:0] DMG_WRONG_C   = 4'(DMG_WRONG);
    localparam logic [3:0] DMG_TIMEOUT_C = 4'(DMG_TIMEOUT);
    localparam logic [2:0] BLINK_C       = 3'(BLINK_TICKS);

    state_t     state_q, state_d;
    logic [3:0] hp_q, hp_d;
    logic [3:0] time_left_q, time_left_d;
    logic [2:0] score_q, score_d;
    logic [3:0] dmg_q, dmg_d;
    logic [2:0] blink_q, blink_d;
    logic       next_q_q, next_q_d;
    logic       damage_q, damage_d;
    logic       game_over_q, game_over_d;
    logic       game_clear_q, game_clear_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            hp_q         <= HP_MAX_C;
            time_left_q  <= 4'd0;
            score_q      <= 3'd0;
            dmg_q        <= 4'd0;
            blink_q      <= 3'd0;
            next_q_q     <= 1'b0;
            damage_q     <= 1'b0;
            game_over_q  <= 1'b0;
            game_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            time_left_q  <= time_left_d;
            score_q      <= score_d;
            dmg_q        <= dmg_d;
            blink_q      <= blink_d;
            next_q_q     <= next_q_d;
            damage_q     <= damage_d;
            game_over_q  <= game_over_d;
            game_clear_q <= game_clear_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        time_left_d = time_left_q;
        score_d     = score_q;
        dmg_d       = dmg_q;
        damage_d    = 1'b0;
        // Blink runs off the timebase in every state; a new hit overrides below.
        blink_d     = (tick_i && blink_q != 3'd0) ? blink_q - 3'd1 : blink_q;

        unique case (state_q)
            S_IDLE: begin
                hp_d    = HP_MAX_C;
                score_d = 3'd0;
                if (start_i) state_d = S_NEXT;
            end
            S_NEXT: begin
                time_left_d = TIME_LIMIT_C;
                state_d     = S_ASK;
            end
            S_ASK: begin
                // A judgment always beats a simultaneous expiring tick.
                if (judg_valid_i && judg_i == 2'b01) begin
                    score_d = score_q + 3'd1;
                    state_d = (score_d == WIN_COUNT_C) ? S_CLEAR : S_NEXT;
                end else if (judg_valid_i && judg_i == 2'b10) begin
                    dmg_d   = DMG_WRONG_C;
                    state_d = S_HIT;
                end else if (tick_i && time_left_q == 4'd1) begin
                    time_left_d = 4'd0;
                    dmg_d       = DMG_TIMEOUT_C;
                    state_d     = S_HIT;
                end else if (tick_i && time_left_q != 4'd0) begin
                    time_left_d = time_left_q - 4'd1;
                end
            end
            S_HIT: begin
                hp_d     = (hp_q <= dmg_q) ? 4'd0 : hp_q - dmg_q;
                damage_d = 1'b1;
                blink_d  = BLINK_C;
                if (hp_d == 4'd0) begin
                    state_d = S_OVER;
                end else begin
                    time_left_d = TIME_LIMIT_C;
                    state_d     = S_ASK;
                end
            end
            S_OVER, S_CLEAR: begin
                if (start_i) begin
                    hp_d    = HP_MAX_C;
                    score_d = 3'd0;
                    state_d = S_NEXT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        next_q_d     = (state_d == S_NEXT);
        game_over_d  = (state_d == S_OVER);
        game_clear_d = (state_d == S_CLEAR);
    end

    assign state_o      = state_q;
    assign hp_o         = hp_q;
    assign time_left_o  = time_left_q;
    assign score_o      = score_q;
    assign next_q_o     = next_q_q;
    assign damage_o     = damage_q;
    assign blink_o      = (blink_q != 3'd0);
    assign game_over_o  = game_over_q;
    assign game_clear_o = game_clear_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// tb/tb_game_round_sequencer.sv - Directed self-checking bench for game_round_sequencer.
module tb_game_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       judg_valid = 1'b0;
    logic [1:0] judg = 2'b00;
    logic [2:0] state;
    logic [3:0] hp;
    logic [3:0] time_left;
    logic [2:0] score;
    logic       next_q;
    logic       damage;
    logic       blink;
    logic       game_over;
    logic       game_clear;

    int n_checks = 0;
    int n_fail   = 0;
    int nq_count = 0;

    always #5 clk = ~clk;

    game_round_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .tick_i       (tick),
        .judg_valid_i (judg_valid),
        .judg_i       (judg),
        .state_o      (state),
        .hp_o         (hp),
        .time_left_o  (time_left),
        .score_o      (score),
        .next_q_o     (next_q),
        .damage_o     (damage),
        .blink_o      (blink),
        .game_over_o  (game_over),
        .game_clear_o (game_clear)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic pulse_judg(input logic [1:0] j);
        judg_valid = 1'b1;
        judg       = j;
        cyc();
        judg_valid = 1'b0;
        judg       = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        expect_eq("rst_state", state, 0);
        expect_eq("rst_hp", hp, 9);
        expect_eq("rst_time", time_left, 0);
        expect_eq("rst_score", score, 0);
        expect_eq("rst_flags", {next_q, damage, blink, game_over, game_clear}, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Start: one NEXT_Q, then ASK with full timer
        pulse_start();
        expect_eq("start_next_state", state, 3);
        expect_eq("start_next_q", next_q, 1);
        cyc();
        expect_eq("ask_state", state, 1);
        expect_eq("ask_time", time_left, 10);
        expect_eq("ask_hp", hp, 9);
        expect_eq("ask_next_q_low", next_q, 0);

        // Timeout: 10 ticks, HP 9 -> 7
        for (int i = 0; i < 9; i++) pulse_tick();
        expect_eq("tick_time1", time_left, 1);
        pulse_tick();
        expect_eq("timeout_hit_state", state, 2);
        expect_eq("timeout_time0", time_left, 0);
        expect_eq("timeout_hp_pending", hp, 9);
        cyc();
        expect_eq("timeout_hp", hp, 7);
        expect_eq("timeout_damage", damage, 1);
        expect_eq("timeout_retry_state", state, 1);
        expect_eq("timeout_retry_time", time_left, 10);
        expect_eq("timeout_no_next_q", next_q, 0);

        // Wrong answer: HP 7 -> 6 two edges later, blink for 3 ticks
        pulse_judg(2'b10);
        expect_eq("wrong_hit_state", state, 2);
        expect_eq("wrong_hp_pending", hp, 7);
        cyc();
        expect_eq("wrong_hp", hp, 6);
        expect_eq("wrong_damage", damage, 1);
        expect_eq("wrong_time", time_left, 10);
        expect_eq("wrong_blink", blink, 1);
        cyc();
        expect_eq("wrong_damage_once", damage, 0);
        pulse_tick();
        expect_eq("blink_t1", blink, 1);
        pulse_tick();
        expect_eq("blink_t2", blink, 1);
        pulse_tick();
        expect_eq("blink_t3", blink, 0);
        expect_eq("blink_time", time_left, 7);

        // Drain HP to 1 with wrong answers, then time out to 0
        for (int i = 0; i < 5; i++) begin
            pulse_judg(2'b10);
            cyc();
        end
        expect_eq("hp_one", hp, 1);
        for (int i = 0; i < 10; i++) pulse_tick();
        expect_eq("final_hit_state", state, 2);
        cyc();
        expect_eq("over_hp", hp, 0);
        expect_eq("over_state", state, 4);
        expect_eq("over_flag", game_over, 1);
        expect_eq("over_time", time_left, 0);
        pulse_judg(2'b01);
        pulse_tick();
        expect_eq("over_hold_state", state, 4);
        expect_eq("over_hold_score", score, 0);

        // Restart from OVER, then five correct answers to CLEAR
        pulse_start();
        expect_eq("restart_state", state, 3);
        expect_eq("restart_hp", hp, 9);
        expect_eq("restart_over_low", game_over, 0);
        cyc();
        for (int k = 1; k <= 5; k++) begin
            pulse_judg(2'b01);
            expect_eq("win_score", score, k);
            if (next_q) nq_count++;
            if (k < 5) begin
                expect_eq("win_next_state", state, 3);
                cyc();
            end
        end
        expect_eq("win_next_q_count", nq_count, 4);
        expect_eq("clear_state", state, 5);
        expect_eq("clear_flag", game_clear, 1);
        pulse_tick();
        expect_eq("clear_hold_time", time_left, 10);

        // Correct answer and expiring tick together: judgment wins
        pulse_start();
        expect_eq("clear_restart_score", score, 0);
        cyc();
        for (int i = 0; i < 9; i++) pulse_tick();
        judg_valid = 1'b1;
        judg       = 2'b01;
        tick       = 1'b1;
        cyc();
        judg_valid = 1'b0;
        judg       = 2'b00;
        tick       = 1'b0;
        expect_eq("race_state", state, 3);
        expect_eq("race_score", score, 1);
        cyc();
        expect_eq("race_hp", hp, 9);
        expect_eq("race_no_damage", damage, 0);
        pulse_judg(2'b00);
        pulse_judg(2'b11);
        expect_eq("ignored_judg_state", state, 1);
        expect_eq("ignored_judg_score", score, 1);

        // Asynchronous reset in the middle of HIT
        pulse_judg(2'b10);
        cyc();
        pulse_judg(2'b10);
        expect_eq("pre_rst_hit", state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("arst_state", state, 0);
        expect_eq("arst_hp", hp, 9);
        expect_eq("arst_score", score, 0);
        expect_eq("arst_time", time_left, 0);
        expect_eq("arst_flags", {next_q, damage, blink, game_over, game_clear}, 0);
        cyc();
        expect_eq("arst_held", hp, 9);
        rst_n = 1'b1;
        cyc();
        pulse_start();
        expect_eq("post_rst_next_q", next_q, 1);
        cyc();
        expect_eq("post_rst_state", state, 1);
        expect_eq("post_rst_time", time_left, 10);
        expect_eq("post_rst_hp", hp, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
